sseg_scanner: RTL and testbench
===============================

# sseg_scanner

Time-multiplexed scan controller for the seven-segment display, sitting directly upstream of the seven-segment decoder. It snapshots a packed vector of 4-bit digit codes once per frame, then steps through the digits. For each digit it drives the decoder's 4-bit `Din` input, the matching active-low anode line and the active-low decimal point. A blanking interval at the start of each digit slot suppresses ghosting.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits; must be ≥ 2.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ BLANK_CYCLES < REFRESH_DIV.

- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `digits` in 4*NUM_DIGITS: digit codes; digit i is `digits[4i+3:4i]`, digit 0 rightmost.
- `digit_en` in NUM_DIGITS: per-digit enable; 0 keeps that anode off for its whole slot.
- `dp_mask` in NUM_DIGITS: 1 lights the decimal point of digit i.
- `Din` out 4: code for the current digit, fed to the decoder.
- `an_n` out NUM_DIGITS: anode selects, active-low, at most one low.
- `dp_n` out 1: decimal point, active-low.
- `frame_tick` out 1: one-cycle pulse on the cycle the snapshot is taken.

## Operation
- Slot counter `cnt` runs 0..REFRESH_DIV-1 and wraps to 0. On wrap, digit index `idx` advances 0..NUM_DIGITS-1, wrapping to 0.
- States:
  - BLANK while `cnt < BLANK_CYCLES`.
  - SHOW otherwise.
  - With BLANK_CYCLES=0, BLANK is never entered.
- SHOW: `an_n[idx]`=0 if `digit_en` of the snapshot is 1 at `idx`; all other anode bits are 1. `dp_n` = ~`dp_mask` snapshot at `idx`.
- BLANK: `an_n` all 1 and `dp_n`=1. `Din` still carries the snapshot code at `idx`.
- Snapshot registers capture `digits`, `digit_en` and `dp_mask`:
  - on the first edge after reset release (`primed` flag, reset 0, set by that edge);
  - at every frame boundary, i.e. the edge where (idx,cnt) goes from (NUM_DIGITS-1, REFRESH_DIV-1) to (0,0).
- `frame_tick`=1 exactly on cycles following a snapshot edge.
- Input changes between snapshots do not affect outputs. This prevents tearing within a frame.
- Widths: `cnt` is $clog2(REFRESH_DIV) bits; `idx` is $clog2(NUM_DIGITS) bits. No arithmetic overflow is permitted; wrap uses compare-and-clear, not natural rollover.

## Timing
- Outputs are registered and computed from the next-state values. `an_n`, `dp_n`, `Din` and `frame_tick` therefore reflect the `cnt`/`idx` present in the same cycle, with no extra latency.
- Reset values: `cnt`=0, `idx`=0, `primed`=0, snapshots=0, `Din`=0, `an_n`=all 1, `dp_n`=1, `frame_tick`=0.
- Reset asserted mid-slot: all registers take reset values immediately (asynchronously). No partial slot completes. After release, scanning restarts at digit 0, slot start (BLANK).
- First edge after release: snapshot taken, `frame_tick`=1, cnt=1.
- Edge n after release: cnt = n mod REFRESH_DIV and idx = (n div REFRESH_DIV) mod NUM_DIGITS.
- Full frame period = NUM_DIGITS*REFRESH_DIV cycles.
- Simultaneous slot wrap and frame wrap: snapshot load and `idx`→0 happen on the same edge. The new snapshot applies to digit 0 of the new frame.

## Structure
- `sseg_pkg` contains:
  - the scan state enum (BLANK, SHOW);
  - constant `SSEG_CODE_W`=4;
  - constant `SSEG_AN_OFF`=1'b1 (anode inactive level).
- One sub-module, `sseg_slot_counter`:
  - parameter REFRESH_DIV;
  - outputs `cnt` and a `slot_wrap` strobe.
- The scanner instantiates `sseg_slot_counter` and holds `idx`, the snapshots and the output registers.

## Test plan
All directed tests use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset/scan: `digits`=16'h4321, `digit_en`=4'hF, `dp_mask`=0, release `rst_n`.
  - Edges 1–1: `an_n`=4'b1111.
  - Edges 2–7: `an_n`=4'b1110, `Din`=1.
  - Edges 10–15: `an_n`=4'b1101, `Din`=2.
  - Edges 26–31: `an_n`=4'b0111, `Din`=4.
- Snapshot: change `digits` to 16'h8765 at edge 12.
  - `Din` stays 2, then 3, 4 through edge 31.
  - `frame_tick`=1 at edge 32.
  - `Din`=5 at edge 34.
- Mask/dp: `digit_en`=4'b1011, `dp_mask`=4'b0001.
  - During slot 2, `an_n`=4'b1111 throughout.
  - In slot 0, `dp_n`=0 only on edges 2–7.
- Blanking off: BLANK_CYCLES=0 → `an_n`=4'b1110 from edge 1, with no all-ones cycle between slots.
- Async reset mid-slot: drop `rst_n` at edge 13, between clock edges.
  - `an_n`=4'b1111, `Din`=0 and `dp_n`=1 immediately.
  - After release, the scan sequence matches the reset/scan test from edge 1.
- Parameter sweep: NUM_DIGITS=8, REFRESH_DIV=3, BLANK_CYCLES=1.
  - `frame_tick` period = 24 cycles.
  - `an_n` is never more than one bit low in any cycle.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan path.
package sseg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam int   SSEG_CODE_W = 4;
    localparam logic SSEG_AN_OFF = 1'b1;

endpackage

// File: rtl/sseg_slot_counter.sv
// Digit-slot counter: counts 0..REFRESH_DIV-1 and flags the cycle before the wrap.
module sseg_slot_counter #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic [$clog2(REFRESH_DIV)-1:0] cnt,
    output logic                           slot_wrap
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    // Compare-and-clear keeps the count exact for non-power-of-two dividers.
    assign slot_wrap = (cnt == CNT_MAX);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (slot_wrap)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/sseg_scanner.sv
// Seven-segment scan controller: per-frame snapshot of digit codes, one digit per
// slot, with a blanking interval at the start of each slot.
module sseg_scanner
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [SSEG_CODE_W*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]             digit_en,
    input  logic [NUM_DIGITS-1:0]             dp_mask,
    output logic [SSEG_CODE_W-1:0]            Din,
    output logic [NUM_DIGITS-1:0]             an_n,
    output logic                              dp_n,
    output logic                              frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt, cnt_nxt;
    logic          slot_wrap;
    logic [IW-1:0] idx, idx_nxt;
    logic          primed;
    logic          frame_wrap, snap_load;
    scan_state_t   state_nxt;

    logic [SSEG_CODE_W*NUM_DIGITS-1:0] snap_digits, snap_digits_nxt;
    logic [NUM_DIGITS-1:0]             snap_en, snap_en_nxt;
    logic [NUM_DIGITS-1:0]             snap_dp, snap_dp_nxt;
    logic [SSEG_CODE_W-1:0]            din_nxt;
    logic [NUM_DIGITS-1:0]             an_n_nxt;
    logic                              dp_n_nxt;

    sseg_slot_counter #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_slot_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt       (cnt),
        .slot_wrap (slot_wrap)
    );

    assign frame_wrap = slot_wrap && (idx == IDX_MAX);
    assign snap_load  = !primed || frame_wrap;

    // Outputs are registered from next-state values so they line up with cnt/idx.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign state_nxt = SHOW;
        end else begin : g_blank
            assign state_nxt = (cnt_nxt < BLANK_LIM) ? BLANK : SHOW;
        end
    endgenerate

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        cnt_nxt         = slot_wrap ? '0 : cnt + 1'b1;
        idx_nxt         = idx;
        if (slot_wrap)
            idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;

        snap_digits_nxt = snap_load ? digits   : snap_digits;
        snap_en_nxt     = snap_load ? digit_en : snap_en;
        snap_dp_nxt     = snap_load ? dp_mask  : snap_dp;

        din_nxt  = snap_digits_nxt[int'(idx_nxt)*SSEG_CODE_W +: SSEG_CODE_W];
        an_n_nxt = {NUM_DIGITS{SSEG_AN_OFF}};
        dp_n_nxt = 1'b1;
        if (state_nxt == SHOW) begin
            if (snap_en_nxt[idx_nxt])
                an_n_nxt[idx_nxt] = ~SSEG_AN_OFF;
            dp_n_nxt = ~snap_dp_nxt[idx_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            primed      <= 1'b0;
            snap_digits <= '0;
            snap_en     <= '0;
            snap_dp     <= '0;
            Din         <= '0;
            an_n        <= {NUM_DIGITS{SSEG_AN_OFF}};
            dp_n        <= 1'b1;
            frame_tick  <= 1'b0;
        end else begin
            idx         <= idx_nxt;
            primed      <= 1'b1;
            snap_digits <= snap_digits_nxt;
            snap_en     <= snap_en_nxt;
            snap_dp     <= snap_dp_nxt;
            Din         <= din_nxt;
            an_n        <= an_n_nxt;
            dp_n        <= dp_n_nxt;
            frame_tick  <= snap_load;
        end
    end

endmodule

// File: tb/tb_sseg_scanner.sv
// Directed bench for sseg_scanner: three configurations run in lockstep against a
// frame-level reference model through a scoreboard queue, plus fixed-value checks.
module tb_sseg_scanner;

    typedef struct packed {
        logic [3:0] din;
        logic [7:0] an;
        logic       dp;
        logic       ft;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [15:0] digits_a = 16'h4321;
    logic [3:0]  en_a = 4'hF, dpm_a = 4'h0;
    logic [31:0] digits_c = 32'h8765_4321;
    logic [7:0]  en_c = 8'hFF, dpm_c = 8'h55;

    logic [3:0] din_a, din_b, din_c;
    logic [3:0] an_a, an_b;
    logic [7:0] an_c;
    logic       dp_a, dp_b, dp_c, ft_a, ft_b, ft_c;

    int   errors = 0;
    int   checks = 0;
    int   n = 0;
    exp_t qa[$], qb[$], qc[$];
    logic [31:0] sd_a, sd_c;
    logic [7:0]  se_a, sm_a, se_c, sm_c;

    always #5 clk = ~clk;

    sseg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .digits(digits_a), .digit_en(en_a), .dp_mask(dpm_a),
        .Din(din_a), .an_n(an_a), .dp_n(dp_a), .frame_tick(ft_a));

    sseg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .digits(digits_a), .digit_en(en_a), .dp_mask(dpm_a),
        .Din(din_b), .an_n(an_b), .dp_n(dp_b), .frame_tick(ft_b));

    sseg_scanner #(.NUM_DIGITS(8), .REFRESH_DIV(3), .BLANK_CYCLES(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .digits(digits_c), .digit_en(en_c), .dp_mask(dpm_c),
        .Din(din_c), .an_n(an_c), .dp_n(dp_c), .frame_tick(ft_c));

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h (edge %0d)", tag, obs, expv, n);
        end
    endtask

    function automatic exp_t model(input int e, input int nd, input int rd, input int bc,
                                   input logic [31:0] sd, input logic [7:0] se,
                                   input logic [7:0] sm);
        exp_t r;
        int   c = e % rd;
        int   i = (e / rd) % nd;
        r.din = sd[4*i +: 4];
        r.an  = 8'hFF;
        r.dp  = 1'b1;
        if (c >= bc) begin
            if (se[i]) r.an[i] = 1'b0;
            r.dp = ~sm[i];
        end
        r.ft = (e == 1) || (e % (nd * rd) == 0);
        return r;
    endfunction

    task automatic compare(input string tag, inout exp_t q[$], input logic [3:0] din,
                           input logic [7:0] an, input logic dp, input logic ft);
        exp_t e;
        if (q.size() == 0) begin
            check({tag, "_queue"}, 32'(q.size()), 32'd1);
            return;
        end
        e = q.pop_front();
        check({tag, "_din"}, 32'(din), 32'(e.din));
        check({tag, "_an"},  32'(an),  32'(e.an));
        check({tag, "_dp"},  32'(dp),  32'(e.dp));
        check({tag, "_ft"},  32'(ft),  32'(e.ft));
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        if (n == 1 || n % 32 == 0) begin
            sd_a = 32'(digits_a);
            se_a = 8'(en_a);
            sm_a = 8'(dpm_a);
        end
        if (n == 1 || n % 24 == 0) begin
            sd_c = digits_c;
            se_c = en_c;
            sm_c = dpm_c;
        end
        qa.push_back(model(n, 4, 8, 2, sd_a, se_a, sm_a));
        qb.push_back(model(n, 4, 8, 0, sd_a, se_a, sm_a));
        qc.push_back(model(n, 8, 3, 1, sd_c, se_c, sm_c));
        #1;
        compare("a", qa, din_a, {4'hF, an_a}, dp_a, ft_a);
        compare("b", qb, din_b, {4'hF, an_b}, dp_b, ft_b);
        compare("c", qc, din_c, an_c, dp_c, ft_c);
        check("c_onehot", 32'($countones(~an_c) <= 1), 32'd1);
    endtask

    task automatic run_to(input int target);
        while (n < target) tick();
    endtask

    task automatic model_reset();
        n = 0;
        sd_a = '0; se_a = '0; sm_a = '0;
        sd_c = '0; se_c = '0; sm_c = '0;
        qa.delete(); qb.delete(); qc.delete();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_an",  32'(an_a), 32'hF);
        check("rst_din", 32'(din_a), 32'h0);
        check("rst_dp",  32'(dp_a), 32'h1);
        check("rst_ft",  32'(ft_a), 32'h0);
        rst_n = 1'b1;

        run_to(1);
        check("e1_an_a",   32'(an_a), 32'hF);
        check("e1_an_b",   32'(an_b), 32'hE);
        check("e1_ft_a",   32'(ft_a), 32'h1);
        run_to(5);
        check("e5_an",     32'(an_a), 32'hE);
        check("e5_din",    32'(din_a), 32'h1);
        run_to(8);
        check("e8_blank",  32'(an_a), 32'hF);
        check("e8_b_show", 32'(an_b), 32'hD);
        run_to(12);
        check("e12_an",    32'(an_a), 32'hD);
        check("e12_din",   32'(din_a), 32'h2);
        digits_a = 16'h8765;
        run_to(20);
        check("e20_din",   32'(din_a), 32'h3);
        run_to(28);
        check("e28_an",    32'(an_a), 32'h7);
        check("e28_din",   32'(din_a), 32'h4);
        run_to(32);
        check("e32_ft",    32'(ft_a), 32'h1);
        run_to(34);
        check("e34_din",   32'(din_a), 32'h5);

        en_a  = 4'b1011;
        dpm_a = 4'b0001;
        run_to(67);
        check("e67_dp",    32'(dp_a), 32'h0);
        run_to(72);
        check("e72_dp",    32'(dp_a), 32'h1);
        run_to(82);
        check("e82_an_off", 32'(an_a), 32'hF);
        run_to(100);

        digits_a = 16'h4321;
        en_a     = 4'hF;
        dpm_a    = 4'h0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_to(13);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_an",  32'(an_a), 32'hF);
        check("async_din", 32'(din_a), 32'h0);
        check("async_dp",  32'(dp_a), 32'h1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_to(1);
        check("re1_an",    32'(an_a), 32'hF);
        run_to(5);
        check("re5_an",    32'(an_a), 32'hE);
        check("re5_din",   32'(din_a), 32'h1);
        run_to(12);
        check("re12_din",  32'(din_a), 32'h2);
        run_to(47);
        check("c_e47_ft",  32'(ft_c), 32'h0);
        run_to(48);
        check("c_e48_ft",  32'(ft_c), 32'h1);
        run_to(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
